// File: rtl/queue_drain_stage_pkg.sv
// queue_drain_stage_pkg: shared state encoding and entry-width helper for the drain stage
package queue_drain_stage_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;
    localparam int M_WIDTH_DEF = 8;
    localparam int N_WIDTH_DEF = 8;
    localparam int ENTRY_WIDTH = M_WIDTH_DEF + N_WIDTH_DEF;
    function automatic int entry_width(int m, int n);
        return m + n;
    endfunction
endpackage

// File: rtl/queue_drain_stage_if.sv
// queue_drain_stage_if: queue-side and consumer-side signals of the drain stage
// slave  (the stage): in flush, q_empty, q_dout, out_stall; out q_rd, out_valid, out_data, occupancy
// master (its environment): the mirror image
interface queue_drain_stage_if #(
    parameter int M_WIDTH = 8,
    parameter int N_WIDTH = 8
);
    localparam int W = queue_drain_stage_pkg::entry_width(M_WIDTH, N_WIDTH);
    logic         flush;
    logic         q_empty;
    logic [W-1:0] q_dout;
    logic         q_rd;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_stall;
    logic [1:0]   occupancy;
    modport slave (
        input  flush, q_empty, q_dout, out_stall,
        output q_rd, out_valid, out_data, occupancy
    );
    modport master (
        output flush, q_empty, q_dout, out_stall,
        input  q_rd, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/queue_drain_stage_drain_entry_reg.sv
// drain_entry_reg: entry register with load enable
// clk clock, clr async active-low clear, ld load enable, d data in, q data out
module drain_entry_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= '0;
        else if (ld) q <= d;
endmodule

// File: rtl/queue_drain_stage.sv
// queue_drain_stage: two-entry skid stage draining the M/N entry queue onto a valid/stall consumer
// clk clock, clr async active-low reset, bus (slave): queue pop side and consumer side
module queue_drain_stage
    import queue_drain_stage_pkg::*;
#(
    parameter int M_WIDTH = 8,
    parameter int N_WIDTH = 8
) (
    input logic                 clk,
    input logic                 clr,
    queue_drain_stage_if.slave  bus
);
    localparam int W = entry_width(M_WIDTH, N_WIDTH);
    state_t       state;
    logic         pop, drain, main_ld, skid_ld;
    logic [W-1:0] main_q, skid_q, main_d;
    // Pop eligibility uses only registered state, so the consumer stall never reaches the queue pointer
    assign pop     = clr & ~bus.flush & ~bus.q_empty & (state != TWO);
    assign drain   = bus.out_valid & ~bus.out_stall;
    assign main_ld = ~bus.flush & ((state == TWO) ? drain : pop & ((state == EMPTY) | drain));
    assign skid_ld = pop & ~drain & (state == ONE);
    assign main_d  = (state == TWO) ? skid_q : bus.q_dout;
    always_ff @(posedge clk or negedge clr)
        if (!clr) state <= EMPTY;
        else if (bus.flush) state <= EMPTY;
        else state <= (state == EMPTY) ? (pop ? ONE : EMPTY) :
                      (state == ONE)   ? ((pop & ~drain) ? TWO : (~pop & drain) ? EMPTY : ONE) :
                      (drain ? ONE : TWO);
    drain_entry_reg #(.W(W)) u_main (.clk(clk), .clr(clr), .ld(main_ld), .d(main_d), .q(main_q));
    drain_entry_reg #(.W(W)) u_skid (.clk(clk), .clr(clr), .ld(skid_ld), .d(bus.q_dout), .q(skid_q));
    assign bus.q_rd      = pop;
    assign bus.out_valid = (state != EMPTY);
    // Stale register contents are masked so an idle output always reads zero
    assign bus.out_data  = bus.out_valid ? main_q : '0;
    assign bus.occupancy = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
endmodule

// File: tb/tb_queue_drain_stage.sv
// tb_queue_drain_stage: scoreboard bench for queue_drain_stage
module tb_queue_drain_stage;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    queue_drain_stage_if #(.M_WIDTH(8), .N_WIDTH(8)) bus();
    queue_drain_stage #(.M_WIDTH(8), .N_WIDTH(8)) dut (.clk(clk), .clr(clr), .bus(bus));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pops = 0;
    logic [15:0] model[$];
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    int          got_cyc[$];
    bit          popped = 0;
    bit          hold_prev = 0;
    logic [15:0] prev_data = 16'h0;
    logic [15:0] mon_e;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One cycle: drive inputs at the falling edge, predict from the count of held entries
    task automatic step(bit st, bit fe, bit fl);
        logic e_rd;
        bus.out_stall = st;
        bus.flush     = fl;
        bus.q_empty   = fe || model.size() == 0;
        bus.q_dout    = model.size() != 0 ? model[0] : 16'h0;
        #1;
        e_rd = clr && !fl && !bus.q_empty && exp_q.size() < 2;
        check("q_rd", 32'(bus.q_rd), 32'(e_rd));
        check("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() == 0) check("idle_data", 32'(bus.out_data), 32'h0);
        popped = bus.q_rd;
        if (popped) begin
            exp_q.push_back(bus.q_dout);
            pops++;
        end
        #2;
        if (fl) exp_q.delete();
        cyc++;
        @(negedge clk);
        if (popped) void'(model.pop_front());
    endtask

    // Monitor: every handoff must match the oldest unconsumed popped entry
    initial forever begin
        @(negedge clk);
        #2;
        if (!clr) hold_prev = 0;
        else begin
            if (hold_prev && bus.out_valid) check("stall_hold", 32'(bus.out_data), 32'(prev_data));
            if (bus.out_valid && !bus.out_stall) begin
                if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
                else begin
                    mon_e = exp_q.pop_front();
                    check("order", 32'(bus.out_data), 32'(mon_e));
                    got.push_back(bus.out_data);
                    got_cyc.push_back(cyc);
                end
            end
            hold_prev = bus.out_valid && bus.out_stall && !bus.flush;
            prev_data = bus.out_data;
        end
    end

    initial begin
        int p0, g0;
        bus.flush = 0;
        bus.out_stall = 0;
        bus.q_empty = 0;
        bus.q_dout = 16'hffff;
        // Reset: q_rd held low even with a non-empty queue
        @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        check("rst_occ", 32'(bus.occupancy), 32'h0);
        check("rst_q_rd", 32'(bus.q_rd), 32'h0);
        @(negedge clk);
        clr = 1;
        // Two entries, no stall
        model = '{16'h1234, 16'h5678};
        p0 = pops; g0 = got.size();
        repeat (4) step(0, 0, 0);
        check("t1_pops", 32'(pops - p0), 32'd2);
        check("t1_count", 32'(got.size() - g0), 32'd2);
        if (got.size() - g0 == 2) begin
            check("t1_a", 32'(got[g0]), 32'h1234);
            check("t1_b", 32'(got[g0+1]), 32'h5678);
            check("t1_gap", 32'(got_cyc[g0+1] - got_cyc[g0]), 32'd1);
        end
        check("t1_occ", 32'(bus.occupancy), 32'h0);
        // Stall absorbs exactly one more pop, then releases in order without gaps
        model = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        p0 = pops; g0 = got.size();
        step(0, 0, 0);
        repeat (4) step(1, 0, 0);
        check("t2_pops", 32'(pops - p0), 32'd2);
        check("t2_occ", 32'(bus.occupancy), 32'd2);
        check("t2_q_rd", 32'(bus.q_rd), 32'h0);
        check("t2_data", 32'(bus.out_data), 32'h1111);
        repeat (6) step(0, 0, 0);
        check("t2_count", 32'(got.size() - g0), 32'd4);
        if (got.size() - g0 == 4)
            for (int i = 0; i < 4; i++) begin
                check("t2_order", 32'(got[g0+i]), 32'(16'h1111 * (i + 1)));
                if (i > 0) check("t2_gap", 32'(got_cyc[g0+i] - got_cyc[g0+i-1]), 32'd1);
            end
        // Flush while holding two entries
        model = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check("t3_valid", 32'(bus.out_valid), 32'h0);
        check("t3_data", 32'(bus.out_data), 32'h0);
        p0 = pops;
        step(0, 0, 0);
        check("t3_repop", 32'(pops - p0), 32'd1);
        step(0, 0, 0);
        check("t3_next", 32'(got[got.size()-1]), 32'hA003);
        repeat (3) step(0, 0, 0);
        // Asynchronous reset with two entries held
        model = '{16'hB001, 16'hB002, 16'hB003};
        step(0, 0, 0);
        step(1, 0, 0);
        check("t4_pre_occ", 32'(bus.occupancy), 32'd2);
        #3 clr = 0;
        #1;
        check("t4_valid", 32'(bus.out_valid), 32'h0);
        check("t4_q_rd", 32'(bus.q_rd), 32'h0);
        check("t4_occ", 32'(bus.occupancy), 32'h0);
        check("t4_data", 32'(bus.out_data), 32'h0);
        model.delete();
        exp_q.delete();
        popped = 0;
        @(negedge clk);
        clr = 1;
        // Random traffic
        repeat (10000) begin
            if (model.size() < 4 && $urandom_range(1, 0) == 1) model.push_back(16'($urandom));
            step($urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(149, 0) == 0);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 1, 0);
        check("final_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/queue_drain_stage.md
# queue_drain_stage

Two-entry skid stage that sits directly downstream of the M/N entry queue. It pops the queue head whenever it has room and presents entries to the consumer on a valid/stall interface. It sustains one entry per cycle while unstalled. Its registered `q_rd` eligibility keeps the consumer's stall off the queue's read-pointer path.

## Interface
Parameters:
- `M_WIDTH`, 8, width of the modifiable (M) field of an entry
- `N_WIDTH`, 8, width of the fixed (N) field of an entry

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge
- `clr`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous discard of all held entries
- `q_empty`  in  1  queue empty flag
- `q_dout`  in  M_WIDTH+N_WIDTH  queue head entry, `{M,N}`, combinational from the queue
- `q_rd`  out  1  pop request to the queue
- `out_valid`  out  1  `out_data` holds an entry
- `out_data`  out  M_WIDTH+N_WIDTH  oldest held entry, `{M,N}`
- `out_stall`  in  1  consumer cannot accept this cycle
- `occupancy`  out  2  number of held entries, 0..2

## Operation
- State encoding: EMPTY (0 entries), ONE (main register valid), TWO (main and skid registers valid).
- `q_rd = clr & ~flush & ~q_empty & (state != TWO)`.
  - `q_rd` depends only on registered state plus `q_empty`, `flush` and `clr`.
  - `q_rd` never depends on `out_stall`.
- Define `pop = q_rd` and `drain = out_valid & ~out_stall`.
- Transitions when `flush` = 0:
  - EMPTY: on `pop`, `main <= q_dout` and go to ONE; otherwise stay in EMPTY.
  - ONE, `pop & drain`: `main <= q_dout`, stay in ONE.
  - ONE, `pop & ~drain`: `skid <= q_dout`, go to TWO.
  - ONE, `~pop & drain`: go to EMPTY.
  - ONE, neither: hold.
  - TWO (`q_rd` is 0 here): on `drain`, `main <= skid` and go to ONE; otherwise hold.
- `flush` = 1:
  - Next state is EMPTY.
  - `q_rd` = 0 in that cycle.
  - A concurrent drain still counts as a completed handoff to the consumer.
  - Register contents may go stale, but `out_data` must read 0 when `out_valid` = 0.
- Output mapping:
  - `out_valid = (state != EMPTY)`.
  - `out_data = main` when valid, else 0.
  - `occupancy` is 0, 1 or 2 for EMPTY, ONE or TWO.
- Ordering: entries leave in exactly the order popped, with no duplication and no loss.
- Capture rule:
  - The value captured is the `q_dout` present in the pop cycle.
  - The upstream modify path must not target the entry being popped in that same cycle; if it does, the pre-modify value is captured.

## Timing
- Reset (`clr` low, asynchronous):
  - State goes to EMPTY and both registers to 0.
  - `out_valid` = 0, `out_data` = 0, `occupancy` = 0.
  - `q_rd` is forced to 0 for as long as `clr` is low.
- Release of `clr`: the first pop is possible in the first cycle with `clr` high.
- Latency: an entry popped in cycle t is visible on `out_data` in cycle t+1.
- Throughput: with `out_stall` held at 0 and the queue non-empty, one entry per cycle, in steady state ONE.
- Stall rule: while `out_valid` and `out_stall` are both 1, `out_data` is held stable.
- Stall, then release:
  - A stall absorbs at most one further pop, which lands in skid; `q_rd` then drops the next cycle.
  - On release, skid moves to main one cycle after main drains.
  - `q_rd` resumes in the cycle state returns to ONE.
- Reset mid-operation: held entries are lost. Entries never popped remain in the queue, which is cleared by the same `clr`.

## Structure
- Shared package holds:
  - state constants EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11
  - the entry width `M_WIDTH+N_WIDTH`
- Sub-module `drain_entry_reg`:
  - M_WIDTH+N_WIDTH register with load enable and asynchronous active-low clear.
  - Instantiated twice: main and skid.
  - The main register's data input is a 2:1 mux of `q_dout` and skid, selected by `state == TWO`.
- Next-state logic and the `q_rd` equation live in the top module.

## Test plan
- Reset, then a queue holding A=0x1234, B=0x5678 with `out_stall`=0 -> `q_rd` high for 2 cycles; `out_data` = 0x1234 then 0x5678 on consecutive cycles; `occupancy` returns to 0.
- Queue holds 4 entries, `out_stall`=1 from cycle 1 -> exactly 2 pops, `occupancy`=2, `q_rd`=0, `out_data` held at the first entry; releasing the stall delivers all 4 in order with no gaps after refill.
- `flush` in state TWO with the queue non-empty -> next cycle `out_valid`=0, `out_data`=0, `q_rd` was 0 in the flush cycle; the following cycle pops the next queue entry.
- `clr` asserted low mid-stream with `occupancy`=2 -> `out_valid`, `q_rd` and `occupancy` go to 0 immediately, without waiting for a clock edge.
- Random `q_empty`/`out_stall` for 10k cycles against a scoreboard -> strict in-order delivery, no loss or duplication, `out_data` stable whenever `out_valid & out_stall`.
